// File: rtl/cpu_sim_pkg.sv
// Shared types and constants for the write scoreboard checker.
package cpu_sim_pkg;

  // Checker run state
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    PASS  = 2'd2,
    FAIL  = 2'd3
  } state_e;

  // Table entry target kind
  localparam logic KIND_REG = 1'b0;
  localparam logic KIND_MEM = 1'b1;

  // Reported failure reason
  localparam logic [1:0] FAIL_NONE     = 2'd0;
  localparam logic [1:0] FAIL_TIMEOUT  = 2'd1;
  localparam logic [1:0] FAIL_MISMATCH = 2'd2;

  // Saturating 8-bit increment
  function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic inc);
    return (inc && (v != 8'hFF)) ? v + 8'd1 : v;
  endfunction

endpackage

// File: rtl/wr_event_detect.sv
// Write-strobe falling-edge detector with payload capture.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   strobe     : write strobe
//   din        : payload, captured every cycle strobe is high
//   evt_c      : one-cycle event, strobe was high last cycle and is low now
//   dout       : payload from the last high cycle of the strobe
module wr_event_detect #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         strobe,
  input  logic [W-1:0] din,
  output logic         evt_c,
  output logic [W-1:0] dout
);

  logic         strobe_q, strobe_d;
  logic [W-1:0] cap_q, cap_d;

  // Capture holds the last value seen while the strobe was high
  always_comb begin
    strobe_d = strobe;
    cap_d    = strobe ? din : cap_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      strobe_q <= 1'b0;
      cap_q    <= '0;
    end else begin
      strobe_q <= strobe_d;
      cap_q    <= cap_d;
    end
  end

  assign evt_c = strobe_q & ~strobe;
  assign dout  = cap_q;

endmodule

// File: rtl/write_scoreboard.sv
// Write scoreboard: compares completed register-file / RAM writes against a
// programmable table of expected (kind, address, value) entries.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   rf_wr/rf_idx         : register-file write strobe and destination
//   mem_wr/mem_addr      : RAM write strobe and address
//   wr_data              : write data shared by both paths
//   cfg_*                : table programming (honoured in IDLE only)
//   start                : arm / re-arm the checker
//   busy/pass/fail       : ARMED / PASS / FAIL state decode
//   fail_code            : none, timeout or mismatch
//   hit_count/miss_count : distinct entries hit / mismatching writes
module write_scoreboard
  import cpu_sim_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned REG_W   = 3,
  parameter int unsigned NUM_CHK = 4,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned STRICT  = 1,
  localparam int unsigned IDX_W  = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1,
  localparam int unsigned HIT_W  = $clog2(NUM_CHK + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rf_wr,
  input  logic [REG_W-1:0]  rf_idx,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic              cfg_en,
  input  logic              cfg_kind,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              start,
  output logic              busy,
  output logic              pass,
  output logic              fail,
  output logic [1:0]        fail_code,
  output logic [HIT_W-1:0]  hit_count,
  output logic [7:0]        miss_count
);

  localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e                           state_q, state_d;
  logic [NUM_CHK-1:0]               en_q, en_d;
  logic [NUM_CHK-1:0]               kind_q, kind_d;
  logic [NUM_CHK-1:0][ADDR_W-1:0]   addr_q, addr_d;
  logic [NUM_CHK-1:0][DATA_W-1:0]   data_q, data_d;
  logic [NUM_CHK-1:0]               hit_q, hit_d;
  logic [HIT_W-1:0]                 hit_cnt_q, hit_cnt_d;
  logic [7:0]                       miss_cnt_q, miss_cnt_d;
  logic [TMR_W-1:0]                 timer_q, timer_d;
  logic [1:0]                       code_q, code_d;

  logic                      rf_evt_c, mem_evt_c;
  logic [REG_W+DATA_W-1:0]   rf_cap;
  logic [ADDR_W+DATA_W-1:0]  mem_cap;
  logic [REG_W-1:0]          rf_cap_idx;
  logic [DATA_W-1:0]         rf_cap_data;
  logic [ADDR_W-1:0]         mem_cap_addr;
  logic [DATA_W-1:0]         mem_cap_data;

  logic [NUM_CHK-1:0] rf_addr_m, rf_exact, mem_addr_m, mem_exact;
  logic [NUM_CHK-1:0] rf_sel, mem_sel;
  logic               rf_miss, mem_miss, arm;

  wr_event_detect #(.W(REG_W + DATA_W)) u_rf_det (
    .clk    (clk),
    .reset  (reset),
    .strobe (rf_wr),
    .din    ({rf_idx, wr_data}),
    .evt_c  (rf_evt_c),
    .dout   (rf_cap)
  );

  wr_event_detect #(.W(ADDR_W + DATA_W)) u_mem_det (
    .clk    (clk),
    .reset  (reset),
    .strobe (mem_wr),
    .din    ({mem_addr, wr_data}),
    .evt_c  (mem_evt_c),
    .dout   (mem_cap)
  );

  assign rf_cap_idx   = rf_cap[REG_W+DATA_W-1 -: REG_W];
  assign rf_cap_data  = rf_cap[DATA_W-1:0];
  assign mem_cap_addr = mem_cap[ADDR_W+DATA_W-1 -: ADDR_W];
  assign mem_cap_data = mem_cap[DATA_W-1:0];

  // Lowest set bit only, so duplicate entries are consumed one per event
  function automatic logic [NUM_CHK-1:0] first_one(input logic [NUM_CHK-1:0] v);
    logic [NUM_CHK-1:0] r;
    logic               found;
    r     = '0;
    found = 1'b0;
    for (int i = 0; i < int'(NUM_CHK); i++) begin
      if (v[i] && !found) begin
        r[i]  = 1'b1;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // Per-entry address and exact matches for both captured writes
  always_comb begin
    rf_addr_m  = '0;
    rf_exact   = '0;
    mem_addr_m = '0;
    mem_exact  = '0;
    for (int i = 0; i < int'(NUM_CHK); i++) begin
      rf_addr_m[i]  = en_q[i] && (kind_q[i] == KIND_REG) &&
                      (addr_q[i][REG_W-1:0] == rf_cap_idx);
      rf_exact[i]   = rf_addr_m[i] && (data_q[i] == rf_cap_data);
      mem_addr_m[i] = en_q[i] && (kind_q[i] == KIND_MEM) &&
                      (addr_q[i] == mem_cap_addr);
      mem_exact[i]  = mem_addr_m[i] && (data_q[i] == mem_cap_data);
    end
  end

  // A write equal to an already-hit entry is neither a hit nor a mismatch
  assign rf_sel   = rf_evt_c  ? first_one(rf_exact  & ~hit_q) : '0;
  assign mem_sel  = mem_evt_c ? first_one(mem_exact & ~hit_q) : '0;
  assign rf_miss  = rf_evt_c  && (|rf_addr_m)  && !(|rf_exact);
  assign mem_miss = mem_evt_c && (|mem_addr_m) && !(|mem_exact);

  // Next-state and table/counter update
  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    kind_d     = kind_q;
    addr_d     = addr_q;
    data_d     = data_q;
    hit_d      = hit_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    timer_d    = timer_q;
    code_d     = code_q;
    arm        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cfg_we && (32'(cfg_idx) < NUM_CHK)) begin
          en_d[cfg_idx]   = cfg_en;
          kind_d[cfg_idx] = cfg_kind;
          addr_d[cfg_idx] = cfg_addr;
          data_d[cfg_idx] = cfg_data;
        end
        arm = start;
      end
      ARMED: begin
        hit_d      = hit_q | rf_sel | mem_sel;
        hit_cnt_d  = hit_cnt_q + HIT_W'(|rf_sel) + HIT_W'(|mem_sel);
        miss_cnt_d = sat_inc8(sat_inc8(miss_cnt_q, rf_miss), mem_miss);
        // Mismatch beats completion, completion beats timeout
        if ((STRICT != 0) && (rf_miss || mem_miss)) begin
          state_d = FAIL;
          code_d  = FAIL_MISMATCH;
        end else if ((hit_d & en_q) == en_q) begin
          state_d = PASS;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          state_d = FAIL;
          code_d  = FAIL_TIMEOUT;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      PASS, FAIL: arm = start;
      default: state_d = IDLE;
    endcase

    // Arming clears run results; an empty table completes immediately
    if (arm) begin
      hit_d      = '0;
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
      timer_d    = '0;
      code_d     = FAIL_NONE;
      state_d    = (|en_d) ? ARMED : PASS;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      en_q       <= '0;
      kind_q     <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      hit_q      <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      timer_q    <= '0;
      code_q     <= FAIL_NONE;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      kind_q     <= kind_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      hit_q      <= hit_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      timer_q    <= timer_d;
      code_q     <= code_d;
    end
  end

  assign busy       = (state_q == ARMED);
  assign pass       = (state_q == PASS);
  assign fail       = (state_q == FAIL);
  assign fail_code  = code_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_write_scoreboard.sv
// Self-checking bench for write_scoreboard: directed scenarios plus random
// per-cycle stimulus, every cycle compared with a behavioural model.
module tb_write_scoreboard;

  localparam int TIMEOUT = 16;
  localparam int NCHK    = 4;

  localparam int S_IDLE  = 0;
  localparam int S_ARMED = 1;
  localparam int S_PASS  = 2;
  localparam int S_FAIL  = 3;

  logic       clk;
  logic       reset;
  logic       rf_wr;
  logic [2:0] rf_idx;
  logic       mem_wr;
  logic [5:0] mem_addr;
  logic [7:0] wr_data;
  logic       cfg_we;
  logic [1:0] cfg_idx;
  logic       cfg_en;
  logic       cfg_kind;
  logic [5:0] cfg_addr;
  logic [7:0] cfg_data;
  logic       start;
  logic       busy;
  logic       pass;
  logic       fail;
  logic [1:0] fail_code;
  logic [2:0] hit_count;
  logic [7:0] miss_count;

  write_scoreboard #(
    .DATA_W (8),
    .ADDR_W (6),
    .REG_W  (3),
    .NUM_CHK(NCHK),
    .TIMEOUT(TIMEOUT),
    .STRICT (1)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .rf_wr     (rf_wr),
    .rf_idx    (rf_idx),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .wr_data   (wr_data),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_en    (cfg_en),
    .cfg_kind  (cfg_kind),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .start     (start),
    .busy      (busy),
    .pass      (pass),
    .fail      (fail),
    .fail_code (fail_code),
    .hit_count (hit_count),
    .miss_count(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int t0    = 0;

  // Reference model state
  int m_state, m_hits, m_miss, m_code, m_timer;
  bit t_en[NCHK], t_kind[NCHK], t_hit[NCHK];
  int t_addr[NCHK], t_data[NCHK];
  bit p_rf, p_mem;
  int c_rf_idx, c_rf_data, c_mem_addr, c_mem_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic m_arm();
    int n_en = 0;
    for (int i = 0; i < NCHK; i++) begin
      t_hit[i] = 1'b0;
      if (t_en[i]) n_en++;
    end
    m_hits  = 0;
    m_miss  = 0;
    m_timer = 0;
    m_code  = 0;
    m_state = (n_en > 0) ? S_ARMED : S_PASS;
  endtask

  // One completed write against the expected table
  task automatic m_apply(input bit kind, input int a, input int d, inout bit mism);
    bit addr_any = 0;
    bit exact_any = 0;
    bit done = 0;
    for (int i = 0; i < NCHK; i++) begin
      bit am;
      am = t_en[i] && (t_kind[i] == kind) &&
           (kind ? (t_addr[i] == a) : ((t_addr[i] % 8) == a));
      if (am) begin
        addr_any = 1;
        if (t_data[i] == d) exact_any = 1;
      end
      if (am && t_data[i] == d && !t_hit[i] && !done) begin
        t_hit[i] = 1;
        m_hits++;
        done = 1;
      end
    end
    if (addr_any && !exact_any) begin
      mism = 1;
      if (m_miss < 255) m_miss++;
    end
  endtask

  // Advance the model by one clock using the inputs currently driven
  task automatic model_step();
    bit rf_evt, mem_evt, mism, all_hit;
    if (reset) begin
      m_state = S_IDLE;
      m_hits = 0; m_miss = 0; m_code = 0; m_timer = 0;
      for (int i = 0; i < NCHK; i++) begin
        t_en[i] = 0; t_kind[i] = 0; t_hit[i] = 0; t_addr[i] = 0; t_data[i] = 0;
      end
      p_rf = 0; p_mem = 0;
      c_rf_idx = 0; c_rf_data = 0; c_mem_addr = 0; c_mem_data = 0;
      return;
    end
    rf_evt  = p_rf && !rf_wr;
    mem_evt = p_mem && !mem_wr;
    case (m_state)
      S_IDLE: begin
        if (cfg_we) begin
          t_en[cfg_idx]   = cfg_en;
          t_kind[cfg_idx] = cfg_kind;
          t_addr[cfg_idx] = cfg_addr;
          t_data[cfg_idx] = cfg_data;
        end
        if (start) m_arm();
      end
      S_ARMED: begin
        mism = 0;
        if (rf_evt)  m_apply(1'b0, c_rf_idx, c_rf_data, mism);
        if (mem_evt) m_apply(1'b1, c_mem_addr, c_mem_data, mism);
        all_hit = 1;
        for (int i = 0; i < NCHK; i++) if (t_en[i] && !t_hit[i]) all_hit = 0;
        if (mism) begin
          m_state = S_FAIL; m_code = 2;
        end else if (all_hit) begin
          m_state = S_PASS;
        end else if (m_timer == TIMEOUT - 1) begin
          m_state = S_FAIL; m_code = 1;
        end else begin
          m_timer++;
        end
      end
      default: if (start) m_arm();
    endcase
    p_rf  = rf_wr;
    p_mem = mem_wr;
    if (rf_wr)  begin c_rf_idx = rf_idx;    c_rf_data = wr_data;  end
    if (mem_wr) begin c_mem_addr = mem_addr; c_mem_data = wr_data; end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    chk("busy",       busy,       m_state == S_ARMED);
    chk("pass",       pass,       m_state == S_PASS);
    chk("fail",       fail,       m_state == S_FAIL);
    chk("fail_code",  fail_code,  m_code);
    chk("hit_count",  hit_count,  m_hits);
    chk("miss_count", miss_count, m_miss);
  endtask

  task automatic cfg(input int idx, input bit en, input bit kind, input int a, input int d);
    cfg_we = 1; cfg_idx = 2'(idx); cfg_en = en; cfg_kind = kind;
    cfg_addr = 6'(a); cfg_data = 8'(d);
    cycle();
    cfg_we = 0;
  endtask

  task automatic do_start();
    start = 1;
    cycle();
    start = 0;
    t0 = cyc;
  endtask

  // Strobe high for 'hold' cycles, then low with junk on the bus
  task automatic wr(input bit do_rf, input bit do_mem, input int idx, input int a,
                    input int d, input int hold);
    rf_wr = do_rf; mem_wr = do_mem;
    rf_idx = 3'(idx); mem_addr = 6'(a); wr_data = 8'(d);
    repeat (hold) cycle();
    rf_wr = 0; mem_wr = 0;
    rf_idx = 3'($urandom); mem_addr = 6'($urandom); wr_data = 8'($urandom);
    cycle();
  endtask

  task automatic do_reset();
    reset = 1;
    cycle();
    reset = 0;
  endtask

  task automatic load_std();
    cfg(0, 1, 1'b0, 0, 1);
    cfg(1, 1, 1'b1, 8'h0F, 1);
    cfg(2, 1, 1'b1, 8'h10, 2);
  endtask

  int addr_pool;

  initial begin
    reset = 1; rf_wr = 0; rf_idx = 0; mem_wr = 0; mem_addr = 0; wr_data = 0;
    cfg_we = 0; cfg_idx = 0; cfg_en = 0; cfg_kind = 0; cfg_addr = 0; cfg_data = 0;
    start = 0;
    repeat (2) cycle();
    chk("rst_busy", busy, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fail", fail, 0);
    reset = 0;

    // Program sequence; a cfg write while armed must be ignored
    load_std();
    do_start();
    cfg(3, 1, 1'b0, 2, 9);
    wr(1, 0, 0, 0, 1, 1);
    chk("prog_hit1", hit_count, 1);
    wr(0, 1, 0, 8'h0F, 1, 1);
    chk("prog_hit2", hit_count, 2);
    mem_wr = 1; mem_addr = 6'h10; wr_data = 8'd2;
    cycle();
    mem_wr = 0; mem_addr = 6'h10; wr_data = 8'd99;
    chk("prog_pass_early", pass, 0);
    cycle();
    chk("prog_pass", pass, 1);
    chk("prog_fail", fail, 0);
    chk("prog_hit3", hit_count, 3);

    // Wrong value with strict checking
    do_reset();
    load_std();
    do_start();
    wr(1, 0, 0, 0, 1, 1);
    wr(0, 1, 0, 8'h10, 3, 1);
    chk("wrong_fail", fail, 1);
    chk("wrong_code", fail_code, 2);
    chk("wrong_miss", miss_count, 1);
    wr(0, 1, 0, 8'h0F, 1, 1);
    wr(0, 1, 0, 8'h10, 2, 1);
    chk("wrong_sticky", pass, 0);

    // Timeout with one write never driven
    do_reset();
    load_std();
    do_start();
    wr(1, 0, 0, 0, 1, 1);
    wr(0, 1, 0, 8'h0F, 1, 1);
    for (int k = 0; k < 24 && !fail; k++) cycle();
    chk("to_cycle", cyc - t0, TIMEOUT);
    chk("to_code", fail_code, 1);

    // Simultaneous, duplicate and long-strobe writes
    do_reset();
    load_std();
    cfg(3, 1, 1'b0, 8'h0D, 7);
    do_start();
    wr(1, 1, 0, 8'h0F, 1, 1);
    chk("simul_hit", hit_count, 2);
    wr(1, 0, 0, 0, 1, 1);
    chk("dup_hit", hit_count, 2);
    chk("dup_miss", miss_count, 0);
    rf_wr = 1; rf_idx = 3'd5;
    for (int k = 0; k < 5; k++) begin
      wr_data = (k == 4) ? 8'd7 : 8'($urandom_range(8, 200));
      cycle();
    end
    rf_wr = 0; wr_data = 8'd55;
    cycle();
    chk("long_hit", hit_count, 3);
    chk("long_fail", fail, 0);
    wr(0, 1, 0, 8'h10, 2, 2);
    chk("long_pass", pass, 1);

    // Reset mid-run clears the table; empty table passes at once
    do_reset();
    load_std();
    do_start();
    wr(1, 0, 0, 0, 1, 1);
    chk("mid_hit", hit_count, 1);
    do_reset();
    chk("mid_busy", busy, 0);
    chk("mid_hitcnt", hit_count, 0);
    do_start();
    chk("empty_pass", pass, 1);

    // Random tables and per-cycle random traffic
    for (int r = 0; r < 30; r++) begin
      do_reset();
      for (int i = 0; i < NCHK; i++) begin
        addr_pool = $urandom_range(0, 3) + ($urandom_range(0, 1) ? 8 : 0);
        cfg(i, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), addr_pool,
            $urandom_range(0, 2));
      end
      do_start();
      for (int k = 0; k < 30; k++) begin
        reset    = ($urandom_range(0, 63) == 0);
        start    = ($urandom_range(0, 9) == 0);
        cfg_we   = ($urandom_range(0, 7) == 0);
        cfg_idx  = 2'($urandom);
        cfg_en   = 1'($urandom);
        cfg_kind = 1'($urandom);
        cfg_addr = 6'($urandom_range(0, 11));
        cfg_data = 8'($urandom_range(0, 2));
        rf_wr    = ($urandom_range(0, 9) < 4);
        mem_wr   = ($urandom_range(0, 9) < 4);
        rf_idx   = 3'($urandom_range(0, 3));
        mem_addr = 6'($urandom_range(0, 3) + ($urandom_range(0, 1) ? 8 : 0));
        wr_data  = 8'($urandom_range(0, 2));
        cycle();
      end
      reset = 0; start = 0; cfg_we = 0; rf_wr = 0; mem_wr = 0;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
